// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types for the data-memory arbiter: arbitration FSM state
//            encodings and the read-return owner tag.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbitration FSM states
    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,   // normal arbitration, core priority
        ST_DRAIN  = 2'd1,   // entering lock: wait for outstanding loads
        ST_LOCK   = 2'd2,   // ext owns the memory exclusively
        ST_DRAIN2 = 2'd3    // leaving lock: wait for outstanding loads
    } arb_state_e;

    // Which requester a returning load belongs to
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_e;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rd_return_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_rd_return_pipe
// Purpose  : MEM_LAT-deep shift register of {valid, owner} that tracks loads
//            in flight so read data can be routed back to the issuing port.
// Ports    : clk, reset (sync, active-low)
//            issue_valid/issue_owner : load issued to memory this cycle
//            ret_valid/ret_owner     : load whose data is on mem_rdata now
//            empty                   : no load in flight
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter_rd_return_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   issue_valid,
    input  owner_e issue_owner,
    output logic   ret_valid,
    output owner_e ret_owner,
    output logic   empty
);

    logic [MEM_LAT-1:0] valid_q, valid_d;
    logic [MEM_LAT-1:0] owner_q, owner_d;

    always_comb begin
        valid_d    = '0;
        owner_d    = '0;
        valid_d[0] = issue_valid;
        owner_d[0] = issue_owner;
        for (int i = 1; i < MEM_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign ret_valid = valid_q[MEM_LAT-1];
    assign ret_owner = owner_e'(owner_q[MEM_LAT-1]);
    assign empty     = ~|valid_q;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the pipeline MEM stage
//            (core port) and an external loader/debug port (ext port). One
//            access per cycle; load data returns MEM_LAT cycles after grant
//            to the port that issued it. Core has priority, ext is forced a
//            grant after STARVE_MAX consecutive denials, and ext_lock gives
//            ext exclusive ownership once outstanding loads have drained.
// Ports    : clk, reset (sync, active-low)
//            core_* : req/we/addr/wdata/be in; gnt/stall/rvalid/rdata out
//            ext_*  : req/we/addr/wdata/be/lock in; gnt/rvalid/rdata out
//            mem_*  : en/we/addr/wdata/be out; rdata in
//            perf_stall_cnt/perf_ext_cnt out (only with DMEM_ARB_PERF_EN)
// Config   : `define DMEM_ARB_PERF_EN adds saturating stall/ext-grant counters
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    input  logic [DW/8-1:0] core_be,
    output logic            core_gnt,
    output logic            core_stall,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    input  logic            ext_req,
    input  logic            ext_we,
    input  logic [AW-1:0]   ext_addr,
    input  logic [DW-1:0]   ext_wdata,
    input  logic [DW/8-1:0] ext_be,
    input  logic            ext_lock,
    output logic            ext_gnt,
    output logic            ext_rvalid,
    output logic [DW-1:0]   ext_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_ext_cnt,
`endif
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        starve_full;
    logic        pipe_empty;
    logic        ret_valid;
    owner_e      ret_owner;
    logic        issue_load;
    owner_e      issue_owner;

    assign starve_full = (starve_q == SW'(STARVE_MAX));

    // Grants, next state and starvation counter. Grants are gated by reset
    // so nothing reaches memory while reset is held.
    always_comb begin
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;

        case (state_q)
            ST_ARB: begin
                ext_gnt  = reset & ext_req & (~core_req | starve_full);
                core_gnt = reset & core_req & ~ext_gnt;
                if (ext_lock) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!ext_lock)      state_d = ST_ARB;
                else if (pipe_empty) state_d = ST_LOCK;
            end
            ST_LOCK: begin
                ext_gnt = reset & ext_req;
                if (!ext_lock) state_d = ST_DRAIN2;
            end
            ST_DRAIN2: begin
                if (pipe_empty) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase

        if (state_q == ST_DRAIN2 || !ext_req || ext_gnt) begin
            starve_d = '0;
        end else if (!starve_full) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Memory side mirrors whichever port is granted; idle bus is all zero.
    always_comb begin
        mem_en    = core_gnt | ext_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_be    = core_be;
        end else if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_be    = ext_be;
        end
    end

    assign issue_load  = mem_en & ~mem_we;
    assign issue_owner = ext_gnt ? OWN_EXT : OWN_CORE;

    dmem_arbiter_rd_return_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rd_return_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_load),
        .issue_owner (issue_owner),
        .ret_valid   (ret_valid),
        .ret_owner   (ret_owner),
        .empty       (pipe_empty)
    );

    // Returning loads are masked while reset is held so in-flight reads
    // never surface.
    assign core_rvalid = reset & ret_valid & (ret_owner == OWN_CORE);
    assign ext_rvalid  = reset & ret_valid & (ret_owner == OWN_EXT);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign ext_rdata   = ext_rvalid  ? mem_rdata : '0;
    assign core_stall  = reset & core_req & ~core_gnt;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_ext_q, perf_ext_d;

    always_comb begin
        perf_stall_d = core_stall ? sat_inc32(perf_stall_q) : perf_stall_q;
        perf_ext_d   = ext_gnt    ? sat_inc32(perf_ext_q)   : perf_ext_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_ext_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_ext_q   <= perf_ext_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_ext_cnt   = perf_ext_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter. Four instances
//            (MEM_LAT = 1..4) share one stimulus; each has its own memory
//            model preloaded with mem[word] = word index.
// Config   : DMEM_ARB_PERF_EN enables the counter checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, ext_req, ext_we, ext_lock;
    logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
    logic [3:0]  core_be, ext_be;

    logic        core_gnt_a [4];
    logic        core_stall_a [4];
    logic        core_rvalid_a [4];
    logic [31:0] core_rdata_a [4];
    logic        ext_gnt_a [4];
    logic        ext_rvalid_a [4];
    logic [31:0] ext_rdata_a [4];
    logic        mem_en_a [4];
    logic        mem_we_a [4];
    logic [31:0] mem_addr_a [4];
    logic [31:0] mem_wdata_a [4];
    logic [3:0]  mem_be_a [4];
    logic [31:0] mem_rdata_a [4];
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_a [4];
    logic [31:0] perf_ext_a [4];
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        logic [31:0] mem [0:63];
        logic [31:0] dq [0:3];
        logic [3:0]  dv;

        dmem_arbiter #(
            .AW(32), .DW(32), .MEM_LAT(g + 1), .STARVE_MAX(4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .core_req    (core_req),
            .core_we     (core_we),
            .core_addr   (core_addr),
            .core_wdata  (core_wdata),
            .core_be     (core_be),
            .core_gnt    (core_gnt_a[g]),
            .core_stall  (core_stall_a[g]),
            .core_rvalid (core_rvalid_a[g]),
            .core_rdata  (core_rdata_a[g]),
            .ext_req     (ext_req),
            .ext_we      (ext_we),
            .ext_addr    (ext_addr),
            .ext_wdata   (ext_wdata),
            .ext_be      (ext_be),
            .ext_lock    (ext_lock),
            .ext_gnt     (ext_gnt_a[g]),
            .ext_rvalid  (ext_rvalid_a[g]),
            .ext_rdata   (ext_rdata_a[g]),
`ifdef DMEM_ARB_PERF_EN
            .perf_stall_cnt (perf_stall_a[g]),
            .perf_ext_cnt   (perf_ext_a[g]),
`endif
            .mem_en      (mem_en_a[g]),
            .mem_we      (mem_we_a[g]),
            .mem_addr    (mem_addr_a[g]),
            .mem_wdata   (mem_wdata_a[g]),
            .mem_be      (mem_be_a[g]),
            .mem_rdata   (mem_rdata_a[g])
        );

        initial begin
            for (int w = 0; w < 64; w++) mem[w] = w;
            for (int i = 0; i < 4; i++) dq[i] = 32'd0;
            dv = 4'd0;
        end

        // Memory model: byte-enabled writes, reads valid g+1 cycles later.
        always @(posedge clk) begin
            if (mem_en_a[g] && mem_we_a[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_a[g][b])
                        mem[mem_addr_a[g][7:2]][8*b +: 8] <= mem_wdata_a[g][8*b +: 8];
            end
            dv    <= {dv[2:0], mem_en_a[g] && !mem_we_a[g]};
            dq[0] <= mem[mem_addr_a[g][7:2]];
            for (int i = 1; i < 4; i++) dq[i] <= dq[i-1];
        end

        assign mem_rdata_a[g] = dv[g] ? dq[g] : 32'hDEAD_BEEF;
    end

    task automatic set_idle;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
        ext_req  = 0; ext_we  = 0; ext_addr  = 0; ext_wdata  = 0; ext_be  = 0;
        ext_lock = 0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 0;
        core_req = 1; core_addr = 100; core_be = 4'hF;
        ext_req  = 1; ext_addr  = 104; ext_be  = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if ({core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k], mem_we_a[k],
                     core_rvalid_a[k], ext_rvalid_a[k]} !== 7'b0) begin
                    tests_failed++;
                    $display("FAIL reset.ctrl L=%0d got gnt=%b/%b stall=%b en=%b we=%b rv=%b/%b exp all 0",
                             k+1, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k],
                             mem_we_a[k], core_rvalid_a[k], ext_rvalid_a[k]);
                end
                tests_run++;
                if ({mem_addr_a[k], mem_wdata_a[k], core_rdata_a[k], ext_rdata_a[k]} !== 128'd0) begin
                    tests_failed++;
                    $display("FAIL reset.data L=%0d got addr=%h rdata=%h/%h exp 0",
                             k+1, mem_addr_a[k], core_rdata_a[k], ext_rdata_a[k]);
                end
            end
            tick();
        end
        set_idle();
        reset = 1;
    endtask

    task automatic test_core_only;
        core_req = 1; core_we = 0; core_addr = 100; core_be = 4'hF;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k], mem_we_a[k]} !== 5'b10010
                || mem_addr_a[k] !== 32'd100) begin
                tests_failed++;
                $display("FAIL core_only.issue L=%0d got gnt=%b/%b stall=%b en=%b we=%b addr=%0d exp 1/0 0 1 0 100",
                         k+1, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k],
                         mem_we_a[k], mem_addr_a[k]);
            end
        end
        tick();
        set_idle();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                logic        ev;
                logic [31:0] ed;
                ev = (c == k + 1);
                ed = ev ? 32'd25 : 32'd0;
                tests_run++;
                if (core_rvalid_a[k] !== ev || core_rdata_a[k] !== ed || ext_rvalid_a[k] !== 1'b0
                    || core_stall_a[k] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL core_only.ret L=%0d cyc=%0d got rv=%b rdata=%0d ext_rv=%b stall=%b exp rv=%b rdata=%0d 0 0",
                             k+1, c, core_rvalid_a[k], core_rdata_a[k], ext_rvalid_a[k],
                             core_stall_a[k], ev, ed);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention;
        core_req = 1; core_addr = 100; core_be = 4'hF;
        ext_req  = 1; ext_addr  = 104; ext_be  = 4'hF;
        for (int c = 0; c < 10; c++) begin
            logic        e;
            logic [31:0] ea;
            e  = (c == 4) || (c == 9);
            ea = e ? 32'd104 : 32'd100;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (ext_gnt_a[k] !== e || core_gnt_a[k] !== !e || core_stall_a[k] !== e
                    || mem_addr_a[k] !== ea) begin
                    tests_failed++;
                    $display("FAIL contention L=%0d cyc=%0d got gnt=%b/%b stall=%b addr=%0d exp %b/%b %b %0d",
                             k+1, c, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_addr_a[k],
                             !e, e, e, ea);
                end
            end
            tick();
        end
        set_idle();
        repeat (6) tick();
`ifdef DMEM_ARB_PERF_EN
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (perf_ext_a[k] !== 32'd2 || perf_stall_a[k] !== 32'd2) begin
                tests_failed++;
                $display("FAIL perf L=%0d got ext=%0d stall=%0d exp 2 2",
                         k+1, perf_ext_a[k], perf_stall_a[k]);
            end
        end
`endif
    endtask

    task automatic test_latency_sweep;
        for (int c = 0; c < 9; c++) begin
            set_idle();
            if (c < 4) begin
                if (c % 2 == 0) begin
                    core_req = 1; core_addr = 32'(96 + 4 * c); core_be = 4'hF;
                end else begin
                    ext_req = 1; ext_addr = 32'(96 + 4 * c); ext_be = 4'hF;
                end
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                int          j;
                logic        ec, ee;
                logic [31:0] ecd, eed;
                j   = c - (k + 1);
                ec  = (j >= 0) && (j < 4) && (j % 2 == 0);
                ee  = (j >= 0) && (j < 4) && (j % 2 == 1);
                ecd = ec ? 32'(24 + j) : 32'd0;
                eed = ee ? 32'(24 + j) : 32'd0;
                if (c < 4) begin
                    tests_run++;
                    if (core_gnt_a[k] !== (c % 2 == 0) || ext_gnt_a[k] !== (c % 2 == 1)) begin
                        tests_failed++;
                        $display("FAIL sweep.gnt L=%0d cyc=%0d got gnt=%b/%b", k+1, c,
                                 core_gnt_a[k], ext_gnt_a[k]);
                    end
                end
                tests_run++;
                if (core_rvalid_a[k] !== ec || ext_rvalid_a[k] !== ee
                    || core_rdata_a[k] !== ecd || ext_rdata_a[k] !== eed) begin
                    tests_failed++;
                    $display("FAIL sweep.ret L=%0d cyc=%0d got rv=%b/%b rdata=%0d/%0d exp rv=%b/%b rdata=%0d/%0d",
                             k+1, c, core_rvalid_a[k], ext_rvalid_a[k], core_rdata_a[k],
                             ext_rdata_a[k], ec, ee, ecd, eed);
                end
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_lock;
        for (int c = 0; c < 16; c++) begin
            set_idle();
            if (c == 0) begin
                core_req = 1; core_addr = 96; core_be = 4'hF;
            end else if (c == 1) begin
                core_req = 1; core_addr = 100; core_be = 4'hF; ext_lock = 1;
            end else if (c <= 8) begin
                core_req = 1; core_addr = 104; core_be = 4'hF; ext_lock = 1;
                ext_req = 1; ext_we = 1; ext_addr = 104; ext_wdata = 4096; ext_be = 4'hF;
            end else if (c <= 11) begin
                core_req = 1; core_addr = 104; core_be = 4'hF;
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                int L;
                L = k + 1;
                if (c <= 1) begin
                    tests_run++;
                    if (core_gnt_a[k] !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL lock.pre L=%0d cyc=%0d got core_gnt=%b exp 1", L, c, core_gnt_a[k]);
                    end
                end else if (c <= 8) begin
                    logic        eg, erv;
                    logic [31:0] erd;
                    eg  = (c >= L + 3);
                    erv = (c == L) || (c == L + 1);
                    erd = (c == L) ? 32'd24 : ((c == L + 1) ? 32'd25 : 32'd0);
                    tests_run++;
                    if (ext_gnt_a[k] !== eg || core_gnt_a[k] !== 1'b0 || core_stall_a[k] !== 1'b1
                        || mem_we_a[k] !== eg || core_rvalid_a[k] !== erv || core_rdata_a[k] !== erd) begin
                        tests_failed++;
                        $display("FAIL lock.hold L=%0d cyc=%0d got gnt=%b/%b stall=%b we=%b rv=%b rdata=%0d exp 0/%b 1 %b %b %0d",
                                 L, c, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_we_a[k],
                                 core_rvalid_a[k], core_rdata_a[k], eg, eg, erv, erd);
                    end
                end else if (c <= 11) begin
                    tests_run++;
                    if (core_gnt_a[k] !== (c == 11) || core_stall_a[k] !== (c != 11)
                        || ext_gnt_a[k] !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL lock.release L=%0d cyc=%0d got gnt=%b/%b stall=%b exp %b/0 %b",
                                 L, c, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], c == 11, c != 11);
                    end
                end else begin
                    logic        ev;
                    logic [31:0] ed;
                    ev = (c == 11 + L);
                    ed = ev ? 32'd4096 : 32'd0;
                    tests_run++;
                    if (core_rvalid_a[k] !== ev || core_rdata_a[k] !== ed) begin
                        tests_failed++;
                        $display("FAIL lock.readback L=%0d cyc=%0d got rv=%b rdata=%0d exp %b %0d",
                                 L, c, core_rvalid_a[k], core_rdata_a[k], ev, ed);
                    end
                end
            end
            tick();
        end
        set_idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_read;
        for (int c = 0; c < 9; c++) begin
            set_idle();
            reset = (c < 2 || c > 3) ? 1'b1 : 1'b0;
            if (c <= 3) begin
                core_req = 1; core_addr = (c == 0) ? 32'd96 : 32'd100; core_be = 4'hF;
            end
            @(negedge clk);
            if (c >= 2) begin
                for (int k = 0; k < 4; k++) begin
                    tests_run++;
                    if ({core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k],
                         core_rvalid_a[k], ext_rvalid_a[k]} !== 6'b0
                        || core_rdata_a[k] !== 32'd0 || ext_rdata_a[k] !== 32'd0) begin
                        tests_failed++;
                        $display("FAIL reset_mid_read L=%0d cyc=%0d got gnt=%b/%b stall=%b en=%b rv=%b/%b rdata=%h exp all 0",
                                 k+1, c, core_gnt_a[k], ext_gnt_a[k], core_stall_a[k], mem_en_a[k],
                                 core_rvalid_a[k], ext_rvalid_a[k], core_rdata_a[k]);
                    end
                end
            end
            tick();
        end
        reset = 1;
    endtask

    initial begin
        reset = 0;
        set_idle();
        repeat (2) tick();
        test_reset();
        test_core_only();
        test_contention();
        test_latency_sweep();
        test_lock();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
